// File: rtl/gray_sobel_pkg.sv
// Shared constants, window type and small arithmetic helpers for gray_sobel.
package gray_sobel_pkg;

  localparam int PIX_W    = 8;
  localparam int GRAD_W   = 11;
  localparam int MAG_W    = 11;
  localparam int PIPE_LAT = 4;

  // 3x3 window, [row offset][col offset][bit]; offset 0 is the oldest row/col
  typedef logic [2:0][2:0][PIX_W-1:0] win_t;

  // Zero-extend a pixel into the signed gradient domain
  function automatic logic signed [GRAD_W-1:0] pix_ext(input logic [PIX_W-1:0] p);
    return signed'({{(GRAD_W-PIX_W){1'b0}}, p});
  endfunction

  // |g| as unsigned; gradients never reach the most negative code, so no overflow
  function automatic logic [MAG_W-1:0] abs_grad(input logic signed [GRAD_W-1:0] g);
    return g[GRAD_W-1] ? MAG_W'(-g) : MAG_W'(g);
  endfunction

endpackage

// File: rtl/gray_sobel_line_buf.sv
// One line of pixel storage: one read port and one write port, registered read.
// A read and a write to the same address in one cycle returns the old contents.
module gray_sobel_line_buf #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 8,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_data_q, rd_data_d;

  // Read data is held between read enables so downstream can sample it late
  always_comb rd_data_d = rd_en ? mem[rd_addr] : rd_data_q;

  // Read data register
  always_ff @(posedge clk) begin
    if (rst) rd_data_q <= '0;
    else     rd_data_q <= rd_data_d;
  end

  // Storage is never cleared; stale contents are hidden by border masking upstream
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/gray_sobel.sv
// Streaming 3x3 Sobel edge detector, 4-cycle fixed latency, no backpressure.
// Build option SOBEL_BINARY_EN: output is a thresholded binary edge map
// (mag >= thresh -> 8'hFF); otherwise the magnitude saturated to 255.
module gray_sobel
  import gray_sobel_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din_sop,
  input  logic             din_eop,
  input  logic             din_vld,
  input  logic [PIX_W-1:0] din,
  input  logic [PIX_W-1:0] thresh,
  output logic             dout_sop,
  output logic             dout_eop,
  output logic             dout_vld,
  output logic [PIX_W-1:0] dout
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0] col_q, col_d, col_cur, col_s1_q, col_s1_d;
  logic [RW-1:0] row_q, row_d, row_cur, row_s1_q, row_s1_d;
  logic [PIPE_LAT-1:0] vld_pipe_q, vld_pipe_d, sop_pipe_q, sop_pipe_d, eop_pipe_q, eop_pipe_d;
  logic [PIX_W-1:0] pix_s1_q, pix_s1_d, lb1_rd, lb2_rd, dout_q, dout_d;
  win_t win_q, win_d;
  logic border_s2_q, border_s2_d, border_s3_q, border_s3_d;
  logic signed [GRAD_W-1:0] gx_q, gx_d, gy_q, gy_d;
  logic [MAG_W-1:0] mag;

  // Row r-1 at this column: written with the live pixel, read before write
  gray_sobel_line_buf #(.DEPTH(IMG_W), .WIDTH(PIX_W), .AW(CW)) u_lb1 (
    .clk(clk), .rst(rst),
    .rd_en(din_vld), .rd_addr(col_cur),
    .wr_en(din_vld), .wr_addr(col_cur), .wr_data(din),
    .rd_data(lb1_rd)
  );

  // Row r-2: read alongside lb1, written one stage later with lb1's read data
  gray_sobel_line_buf #(.DEPTH(IMG_W), .WIDTH(PIX_W), .AW(CW)) u_lb2 (
    .clk(clk), .rst(rst),
    .rd_en(din_vld), .rd_addr(col_cur),
    .wr_en(vld_pipe_q[0]), .wr_addr(col_s1_q), .wr_data(lb1_rd),
    .rd_data(lb2_rd)
  );

  // Position tracking and framing delay line
  always_comb begin
    col_cur = din_sop ? '0 : col_q;
    row_cur = din_sop ? '0 : row_q;
    col_d   = col_q;
    row_d   = row_q;
    if (din_vld) begin
      if (col_cur == COL_LAST) begin
        col_d = '0;
        row_d = (row_cur == ROW_LAST) ? '0 : row_cur + 1'b1;
      end else begin
        col_d = col_cur + 1'b1;
        row_d = row_cur;
      end
    end
    vld_pipe_d = {vld_pipe_q[PIPE_LAT-2:0], din_vld};
    sop_pipe_d = {sop_pipe_q[PIPE_LAT-2:0], din_sop & din_vld};
    eop_pipe_d = {eop_pipe_q[PIPE_LAT-2:0], din_eop & din_vld};
  end

  // Datapath stages; each loads only on its own stage valid
  always_comb begin
    pix_s1_d    = pix_s1_q;
    col_s1_d    = col_s1_q;
    row_s1_d    = row_s1_q;
    win_d       = win_q;
    border_s2_d = border_s2_q;
    gx_d        = gx_q;
    gy_d        = gy_q;
    border_s3_d = border_s3_q;
    dout_d      = dout_q;
    mag         = abs_grad(gx_q) + abs_grad(gy_q);

    if (din_vld) begin
      pix_s1_d = din;
      col_s1_d = col_cur;
      row_s1_d = row_cur;
    end

    if (vld_pipe_q[0]) begin
      for (int i = 0; i < 3; i++) begin
        win_d[i][0] = win_q[i][1];
        win_d[i][1] = win_q[i][2];
      end
      win_d[0][2] = lb2_rd;
      win_d[1][2] = lb1_rd;
      win_d[2][2] = pix_s1_q;
      border_s2_d = (int'(row_s1_q) < 2) || (int'(col_s1_q) < 2);
    end

    if (vld_pipe_q[1]) begin
      gx_d = (pix_ext(win_q[0][2]) + (pix_ext(win_q[1][2]) <<< 1) + pix_ext(win_q[2][2]))
           - (pix_ext(win_q[0][0]) + (pix_ext(win_q[1][0]) <<< 1) + pix_ext(win_q[2][0]));
      gy_d = (pix_ext(win_q[2][0]) + (pix_ext(win_q[2][1]) <<< 1) + pix_ext(win_q[2][2]))
           - (pix_ext(win_q[0][0]) + (pix_ext(win_q[0][1]) <<< 1) + pix_ext(win_q[0][2]));
      border_s3_d = border_s2_q;
    end

    if (vld_pipe_q[2]) begin
      if (border_s3_q) begin
        dout_d = '0;
      end else begin
`ifdef SOBEL_BINARY_EN
        dout_d = (mag >= MAG_W'(thresh)) ? '1 : '0;
`else
        dout_d = (mag > MAG_W'(255)) ? '1 : mag[PIX_W-1:0];
`endif
      end
    end
  end

`ifndef SOBEL_BINARY_EN
  logic unused_thresh;
  assign unused_thresh = ^thresh;
`endif

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      vld_pipe_q  <= '0;
      sop_pipe_q  <= '0;
      eop_pipe_q  <= '0;
      pix_s1_q    <= '0;
      col_s1_q    <= '0;
      row_s1_q    <= '0;
      win_q       <= '0;
      border_s2_q <= 1'b0;
      gx_q        <= '0;
      gy_q        <= '0;
      border_s3_q <= 1'b0;
      dout_q      <= '0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      vld_pipe_q  <= vld_pipe_d;
      sop_pipe_q  <= sop_pipe_d;
      eop_pipe_q  <= eop_pipe_d;
      pix_s1_q    <= pix_s1_d;
      col_s1_q    <= col_s1_d;
      row_s1_q    <= row_s1_d;
      win_q       <= win_d;
      border_s2_q <= border_s2_d;
      gx_q        <= gx_d;
      gy_q        <= gy_d;
      border_s3_q <= border_s3_d;
      dout_q      <= dout_d;
    end
  end

  assign dout_vld = vld_pipe_q[PIPE_LAT-1];
  assign dout_sop = sop_pipe_q[PIPE_LAT-1];
  assign dout_eop = eop_pipe_q[PIPE_LAT-1];
  assign dout     = dout_q;

endmodule
